// File: rtl/cos_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : cos_job_scheduler_if
// Brief    : Job-in / core / result-out signal bundle for cos_job_scheduler.
// Revision : 1.0
// ============================================================================
interface cos_job_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               in_v;
    logic [WIDTH-1:0]               in_x;
    logic                           core_start;
    logic [WIDTH-1:0]               core_v;
    logic [WIDTH-1:0]               core_x;
    logic                           core_done;
    logic [WIDTH-1:0]               core_distance;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH-1:0]               out_distance;
    logic [WIDTH-1:0]               out_v;
    logic [$clog2(DEPTH+1)-1:0]     fifo_count;
    logic                           busy;
    logic                           timeout_err;

    // Scheduler side
    modport slave (
        input  in_valid, in_v, in_x, core_done, core_distance, out_ready,
        output in_ready, core_start, core_v, core_x, out_valid, out_distance,
               out_v, fifo_count, busy, timeout_err
    );

    // Environment side (job producer, core, result consumer)
    modport master (
        output in_valid, in_v, in_x, core_done, core_distance, out_ready,
        input  in_ready, core_start, core_v, core_x, out_valid, out_distance,
               out_v, fifo_count, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/cos_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cos_job_scheduler
// Brief    : Queues (v, x) jobs and launches them one at a time on the cosine core.
// Revision : 1.0
// ============================================================================
module cos_job_scheduler #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    cos_job_scheduler_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [SW-1:0] C_START   = SW'(START_CYCLES);
    localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_v_q [DEPTH];
    logic [WIDTH-1:0]   mem_x_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [SW-1:0]      start_cnt_q, start_cnt_d;
    logic [TW-1:0]      wait_cnt_q, wait_cnt_d;
    logic               core_start_q, core_start_d;
    logic [WIDTH-1:0]   core_v_q, core_v_d;
    logic [WIDTH-1:0]   core_x_q, core_x_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_dist_q, out_dist_d;
    logic [WIDTH-1:0]   out_v_q, out_v_d;
    logic               timeout_q, timeout_d;
    logic               done_q;

    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_done_edge;

    assign w_in_ready  = (count_q < C_DEPTH);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_done_edge = bus.core_done && !done_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        start_cnt_d  = start_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        core_start_d = core_start_q;
        core_v_d     = core_v_q;
        core_x_d     = core_x_q;
        out_valid_d  = out_valid_q;
        out_dist_d   = out_dist_q;
        out_v_d      = out_v_q;
        timeout_d    = timeout_q;
        w_pop        = 1'b0;

        // Consumer handshake first so a same-cycle capture below overrides it
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Launch only with a free result slot, so a capture never overwrites
                if ((count_q != '0) && (!out_valid_q || bus.out_ready)) begin
                    w_pop        = 1'b1;
                    core_v_d     = mem_v_q[rd_ptr_q];
                    core_x_d     = mem_x_q[rd_ptr_q];
                    core_start_d = 1'b1;
                    start_cnt_d  = SW'(1);
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (start_cnt_q < C_START) begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end else begin
                    core_start_d = 1'b0;
                    wait_cnt_d   = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done_edge) begin
                    out_dist_d  = bus.core_distance;
                    out_v_d     = core_v_q;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (wait_cnt_q == C_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            default: begin
                core_start_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_v_q[wr_ptr_q] <= bus.in_v;
            mem_x_q[wr_ptr_q] <= bus.in_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            start_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            core_start_q <= 1'b0;
            core_v_q     <= '0;
            core_x_q     <= '0;
            out_valid_q  <= 1'b0;
            out_dist_q   <= '0;
            out_v_q      <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            start_cnt_q  <= start_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            core_start_q <= core_start_d;
            core_v_q     <= core_v_d;
            core_x_q     <= core_x_d;
            out_valid_q  <= out_valid_d;
            out_dist_q   <= out_dist_d;
            out_v_q      <= out_v_d;
            timeout_q    <= timeout_d;
            done_q       <= bus.core_done;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.core_start   = core_start_q;
    assign bus.core_v       = core_v_q;
    assign bus.core_x       = core_x_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_distance = out_dist_q;
    assign bus.out_v        = out_v_q;
    assign bus.fifo_count   = count_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.timeout_err  = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_cos_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cos_job_scheduler
// Brief    : Directed self-checking bench with a small behavioural cosine core.
// Revision : 1.0
// ============================================================================
module tb_cos_job_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cos_job_scheduler_if #(.WIDTH(16), .DEPTH(4)) bus ();

    cos_job_scheduler #(
        .WIDTH(16), .DEPTH(4), .START_CYCLES(2), .TIMEOUT(255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Core model: done rises 20 cycles after a start edge and stays high until the next start
    logic        auto_core;
    logic        man_done;
    logic [15:0] man_dist;
    logic        model_done;
    logic [15:0] model_dist;
    logic        st_prev;
    int          model_cnt;

    assign bus.core_done     = auto_core ? model_done : man_done;
    assign bus.core_distance = auto_core ? model_dist : man_dist;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_prev    <= 1'b0;
            model_cnt  <= 0;
            model_done <= 1'b0;
            model_dist <= 16'h0000;
        end else begin
            st_prev <= bus.core_start;
            if (bus.core_start && !st_prev) begin
                model_done <= 1'b0;
                model_cnt  <= 20;
                model_dist <= (bus.core_v == 16'h0800) ? 16'h0705 : ~bus.core_v;
            end else if (model_cnt > 1) begin
                model_cnt <= model_cnt - 1;
            end else if (model_cnt == 1) begin
                model_cnt  <= 0;
                model_done <= 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input logic [15:0] v, input logic [15:0] x);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_v     = v;
        bus.in_x     = x;
        while (!bus.in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("push_accept", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        while (!bus.out_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        int          k;
        logic [15:0] ev;

        bus.in_valid  = 1'b0;
        bus.in_v      = '0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        auto_core     = 1'b1;
        man_done      = 1'b0;
        man_dist      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        chk("rst_fifo_count", {29'd0, bus.fifo_count}, 32'd0);
        chk("rst_busy",       {31'd0, bus.busy},       32'd0);
        chk("rst_core_start", {31'd0, bus.core_start}, 32'd0);
        chk("rst_core_v",     {16'd0, bus.core_v},     32'd0);
        chk("rst_timeout",    {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_out_dist",   {16'd0, bus.out_distance}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",   {31'd0, bus.in_ready},   32'd1);

        // Test 1: single job, start width, capture
        push_job(16'h0800, 16'h0400);
        chk("t1_count_before_pop", {29'd0, bus.fifo_count}, 32'd1);
        chk("t1_no_start_yet",     {31'd0, bus.core_start}, 32'd0);
        @(negedge clk);
        chk("t1_start",      {31'd0, bus.core_start}, 32'd1);
        chk("t1_core_v",     {16'd0, bus.core_v},     32'h0800);
        chk("t1_core_x",     {16'd0, bus.core_x},     32'h0400);
        chk("t1_count_pop",  {29'd0, bus.fifo_count}, 32'd0);
        chk("t1_busy",       {31'd0, bus.busy},       32'd1);
        k = 0;
        while (bus.core_start && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk("t1_start_cycles", k, 32'd2);
        wait_out("t1_valid");
        chk("t1_distance", {16'd0, bus.out_distance}, 32'h0705);
        chk("t1_out_v",    {16'd0, bus.out_v},        32'h0800);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t1_consumed", {31'd0, bus.out_valid}, 32'd0);

        // Test 2: five back-to-back jobs fill the FIFO behind the one in flight
        for (int i = 0; i < 5; i++) begin
            push_job(16'h1000 + 16'(i), 16'h0100 + 16'(i));
        end
        chk("t2_count_full", {29'd0, bus.fifo_count}, 32'd4);
        chk("t2_not_ready",  {31'd0, bus.in_ready},   32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_out("t2_valid");
            ev = 16'h1000 + 16'(i);
            chk("t2_out_v",  {16'd0, bus.out_v},        {16'd0, ev});
            chk("t2_dist",   {16'd0, bus.out_distance}, {16'd0, ~ev});
            @(negedge clk);
        end

        // Test 3: back-pressure holds the queue
        bus.out_ready = 1'b0;
        push_job(16'h3000, 16'h0010);
        push_job(16'h3001, 16'h0011);
        push_job(16'h3002, 16'h0012);
        wait_out("t3_valid");
        chk("t3_out_v_a", {16'd0, bus.out_v}, 32'h3000);
        repeat (30) @(negedge clk);
        chk("t3_count_held", {29'd0, bus.fifo_count}, 32'd2);
        chk("t3_idle",       {31'd0, bus.busy},       32'd0);
        chk("t3_held_valid", {31'd0, bus.out_valid},  32'd1);
        chk("t3_held_v",     {16'd0, bus.out_v},      32'h3000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_valid", {31'd0, bus.out_valid},  32'd0);
        chk("t3_release_start", {31'd0, bus.core_start}, 32'd1);
        chk("t3_release_v",     {16'd0, bus.core_v},     32'h3001);
        chk("t3_release_count", {29'd0, bus.fifo_count}, 32'd1);
        wait_out("t3_valid_b");
        chk("t3_out_v_b", {16'd0, bus.out_v}, 32'h3001);
        @(negedge clk);
        wait_out("t3_valid_c");
        chk("t3_out_v_c", {16'd0, bus.out_v}, 32'h3002);
        @(negedge clk);

        // Test 4: done stuck high across the launch
        man_done  = 1'b1;
        man_dist  = 16'hFFFF;
        auto_core = 1'b0;
        push_job(16'h2222, 16'h0111);
        repeat (40) @(negedge clk);
        chk("t4_still_busy",     {31'd0, bus.busy},      32'd1);
        chk("t4_no_false_capt",  {31'd0, bus.out_valid}, 32'd0);
        man_done = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        man_dist = 16'h3333;
        @(negedge clk);
        chk("t4_valid", {31'd0, bus.out_valid},    32'd1);
        chk("t4_dist",  {16'd0, bus.out_distance}, 32'h3333);
        chk("t4_out_v", {16'd0, bus.out_v},        32'h2222);
        @(negedge clk);

        // Test 5: done never rises
        man_done = 1'b0;
        @(negedge clk);
        push_job(16'h4444, 16'h0222);
        push_job(16'hD800, 16'h13FC);
        k = 0;
        while (!bus.timeout_err && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("t5_timeout",      {31'd0, bus.timeout_err}, 32'd1);
        chk("t5_not_early",    {31'd0, (k >= 250)},      32'd1);
        chk("t5_no_result",    {31'd0, bus.out_valid},   32'd0);
        chk("t5_idle",         {31'd0, bus.busy},        32'd0);
        @(negedge clk);
        chk("t5_next_start",   {31'd0, bus.core_start},  32'd1);
        chk("t5_next_v",       {16'd0, bus.core_v},      32'hD800);
        chk("t5_next_x",       {16'd0, bus.core_x},      32'h13FC);

        // Test 6: asynchronous reset in WAIT
        push_job(16'h5555, 16'h0333);
        repeat (10) @(negedge clk);
        chk("t6_busy_pre",  {31'd0, bus.busy},       32'd1);
        chk("t6_count_pre", {29'd0, bus.fifo_count}, 32'd1);
        chk("t6_v_pre",     {16'd0, bus.core_v},     32'hD800);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_start",   {31'd0, bus.core_start},  32'd0);
        chk("t6_rst_count",   {29'd0, bus.fifo_count},  32'd0);
        chk("t6_rst_valid",   {31'd0, bus.out_valid},   32'd0);
        chk("t6_rst_busy",    {31'd0, bus.busy},        32'd0);
        chk("t6_rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
        chk("t6_rst_core_v",  {16'd0, bus.core_v},      32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        man_done = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_late_done_valid", {31'd0, bus.out_valid},  32'd0);
        chk("t6_late_done_busy",  {31'd0, bus.busy},       32'd0);
        chk("t6_late_done_ready", {31'd0, bus.in_ready},   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
